// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the instruction/data memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/mem_wstrb_gen.sv
// rtl/mem_wstrb_gen.sv - byte-enable and misalignment decode for one request
module mem_wstrb_gen
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  input  logic       wr,
  output logic [3:0] wstrb,
  output logic       misalign
);

  logic [3:0] lanes;

  // Size code 3 falls into the word branch.
  always_comb begin
    lanes    = 4'b1111;
    misalign = 1'b0;
    case (size)
      SZ_B: lanes = 4'b0001 << addr_lo;
      SZ_H: begin
        lanes    = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      default: begin
        lanes    = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
    endcase
    wstrb = (wr && !misalign) ? lanes : 4'b0000;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises fetch and load/store ports onto one SRAM-like bus
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FAIR   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_cancel,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              stall_inst,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_misalign,
  output logic              stall_data,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  arb_state_t        state, state_nxt;
  owner_t            owner, last_grant;
  logic              cancel_flag;
  logic              fair_turn, grant_data, take, resp, cancel_hit;
  logic              sel_wr;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_wstrb;
  logic              sel_misalign;

  // Data normally wins; in fair mode the fetch port gets the turn right after a data grant.
  assign fair_turn  = (FAIR != 0) && (last_grant == OWN_DATA) && inst_req;
  assign grant_data = data_req & ~fair_turn;
  assign take       = (state == ST_IDLE) & (inst_req | data_req);
  assign resp       = (state == ST_DATA) & bus_data_ok;
  assign cancel_hit = inst_cancel & (owner == OWN_INST) & (state != ST_IDLE);

  always_comb begin
    sel_wr    = 1'b0;
    sel_size  = SZ_W;
    sel_addr  = inst_addr;
    sel_wdata = '0;
    if (grant_data) begin
      sel_wr    = data_wr;
      sel_size  = (data_size == 2'd3) ? SZ_W : data_size;
      sel_addr  = data_addr;
      sel_wdata = data_wdata;
    end
  end

  mem_wstrb_gen u_wstrb_gen (
    .size     (sel_size),
    .addr_lo  (sel_addr[1:0]),
    .wr       (sel_wr),
    .wstrb    (sel_wstrb),
    .misalign (sel_misalign)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (inst_req | data_req) state_nxt = ST_ADDR;
      ST_ADDR: if (bus_addr_ok) state_nxt = ST_DATA;
      ST_DATA: if (bus_data_ok) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      owner       <= OWN_INST;
      last_grant  <= OWN_INST;
      cancel_flag <= 1'b0;
      bus_req     <= 1'b0;
      bus_wr      <= 1'b0;
      bus_size    <= 2'b00;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_wstrb   <= 4'b0000;
    end else begin
      state <= state_nxt;
      if (take) begin
        owner       <= grant_data ? OWN_DATA : OWN_INST;
        bus_req     <= 1'b1;
        bus_wr      <= sel_wr;
        bus_size    <= sel_size;
        bus_addr    <= sel_addr;
        bus_wdata   <= sel_wdata;
        bus_wstrb   <= sel_wstrb;
        cancel_flag <= 1'b0;
      end else if ((state == ST_ADDR) && bus_addr_ok) begin
        bus_req <= 1'b0;
      end
      if (cancel_hit) cancel_flag <= 1'b1;
      // Completion clears the flag after any same-cycle cancel so IDLE always starts clean.
      if (resp) begin
        last_grant  <= owner;
        cancel_flag <= 1'b0;
      end
    end
  end

  assign inst_data_ok  = resp & (owner == OWN_INST) & ~cancel_flag & ~inst_cancel;
  assign data_data_ok  = resp & (owner == OWN_DATA);
  assign inst_rdata    = bus_rdata;
  assign data_rdata    = bus_rdata;
  assign data_misalign = take & grant_data & sel_misalign;
  assign stall_inst    = inst_req & ~inst_data_ok;
  assign stall_data    = data_req & ~data_data_ok;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_cancel, inst_data_ok, stall_inst;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_data_ok, data_misalign, stall_data;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .stall_inst(stall_inst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .data_misalign(data_misalign), .stall_data(stall_data),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        own;
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        cancel;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } dreq_t;

  exp_t        sb[$];
  logic [31:0] iq[$];
  dreq_t       dq[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int inst_t0 = 0;
  int last_inst_lat = 0;
  int mis_cnt = 0;
  int addr_dly, data_dly;
  int b_st = 0;
  int b_cnt = 0;
  logic  bus_en, b_fire, inst_done, data_done, exp_iok, exp_dok;
  exp_t  e;
  dreq_t d;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h2408_0001 : (a ^ 32'hA5A5_5A5A);
  endfunction

  task automatic push_inst(input logic [31:0] a, input logic cancel);
    iq.push_back(a);
    sb.push_back('{1'b0, a, 1'b0, 2'd2, 32'h0, 4'h0, rd_fn(a), cancel});
  endtask

  task automatic push_data(input logic wr, input logic [1:0] size, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] strb);
    dq.push_back('{a, wr, size, wd});
    sb.push_back('{1'b1, a, wr, (size == 2'd3) ? 2'd2 : size, wd, strb, rd_fn(a), 1'b0});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((sb.size() != 0 || iq.size() != 0 || dq.size() != 0 || inst_req || data_req) && n < 300) begin
      tick();
      n++;
    end
    check_val("quiet_timeout", n < 300, 1);
    tick();
  endtask

  task automatic wait_addr_ok();
    int n = 0;
    while (bus_addr_ok !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check_val("addr_ok_timeout", n < 50, 1);
  endtask

  // Requester agents, bus responder (drive after posedge) and monitor (sample at negedge)
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = 32'hDEAD_BEEF;
      b_fire      = 1'b0;
      if (!rst) begin
        b_st      = 0;
        inst_done = 1'b0;
        data_done = 1'b0;
      end else begin
        if (inst_done) begin inst_done = 1'b0; inst_req = 1'b0; end
        if (data_done) begin data_done = 1'b0; data_req = 1'b0; end
        if (!inst_req && iq.size() > 0) begin
          inst_addr = iq.pop_front();
          inst_req  = 1'b1;
          inst_t0   = cyc;
        end
        if (!data_req && dq.size() > 0) begin
          d = dq.pop_front();
          data_addr = d.addr; data_wr = d.wr; data_size = d.size; data_wdata = d.wdata;
          data_req  = 1'b1;
        end
        if (bus_en) begin
          if (b_st == 0 && bus_req) begin b_st = 1; b_cnt = addr_dly; end
          if (b_st == 1) begin
            if (b_cnt == 0) begin bus_addr_ok = 1'b1; b_st = 2; b_cnt = data_dly; end
            else b_cnt--;
          end else if (b_st == 2) begin
            if (b_cnt == 0) begin
              bus_data_ok = 1'b1;
              b_fire      = 1'b1;
              bus_rdata   = (sb.size() > 0) ? sb[0].rdata : 32'h0;
              b_st        = 0;
            end else b_cnt--;
          end
        end
      end

      @(negedge clk);
      if (rst) begin
        exp_iok = 1'b0;
        exp_dok = 1'b0;
        if (b_fire) begin
          check_val("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            exp_iok = (e.own == 1'b0) && !e.cancel;
            exp_dok = (e.own == 1'b1);
          end
        end
        check_val("inst_data_ok", inst_data_ok, exp_iok);
        check_val("data_data_ok", data_data_ok, exp_dok);
        check_val("stall_inst", stall_inst, inst_req & ~exp_iok);
        check_val("stall_data", stall_data, data_req & ~exp_dok);
        if (exp_iok) begin
          check_val("inst_rdata", inst_rdata, e.rdata);
          inst_done = 1'b1;
          last_inst_lat = cyc - inst_t0;
        end
        if (exp_dok) begin
          if (!e.wr) check_val("data_rdata", data_rdata, e.rdata);
          data_done = 1'b1;
        end
        if (data_misalign === 1'b1) mis_cnt++;
        if (bus_en && (b_st == 1 || bus_addr_ok)) begin
          check_val("addr_phase_front", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            check_val("bus_req_addr", bus_req, 1);
            check_val("bus_addr", bus_addr, sb[0].addr);
            check_val("bus_wr", bus_wr, sb[0].wr);
            check_val("bus_size", bus_size, sb[0].size);
            check_val("bus_wstrb", bus_wstrb, sb[0].wstrb);
            if (sb[0].wr) check_val("bus_wdata", bus_wdata, sb[0].wdata);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mis_base;
    rst = 1'b0; bus_en = 1'b1; addr_dly = 0; data_dly = 0;
    inst_req = 0; inst_addr = 0; inst_cancel = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    inst_done = 0; data_done = 0; b_fire = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_bus_ctl", {bus_req, bus_wr, bus_size, bus_wstrb}, 0);
    check_val("rst_bus_addr", bus_addr, 0);
    check_val("rst_bus_wdata", bus_wdata, 0);
    check_val("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    tick();
    rst = 1'b1;
    tick();

    // single fetch, minimum latency
    push_inst(32'hBFC0_0000, 1'b0);
    wait_quiet();
    check_val("fetch_latency", last_inst_lat, 2);

    // simultaneous requests, then alternating grants D,I,D,I,D,I
    push_data(1'b0, 2'd2, 32'h8000_0010, 32'h0, 4'h0);
    push_inst(32'hBFC0_0010, 1'b0);
    push_data(1'b0, 2'd2, 32'h8000_0020, 32'h0, 4'h0);
    push_inst(32'hBFC0_0014, 1'b0);
    push_data(1'b0, 2'd2, 32'h8000_0030, 32'h0, 4'h0);
    push_inst(32'hBFC0_0018, 1'b0);
    wait_quiet();

    // cancel during DATA with a slow response, then a normal fetch
    data_dly = 2;
    push_inst(32'hBFC0_0100, 1'b1);
    wait_addr_ok();
    tick();
    inst_cancel = 1'b1; inst_req = 1'b0;
    tick();
    inst_cancel = 1'b0;
    wait_quiet();
    data_dly = 0;
    push_inst(32'hBFC0_0104, 1'b0);
    wait_quiet();

    // cancel in the same cycle as bus_data_ok
    push_inst(32'hBFC0_0200, 1'b1);
    wait_addr_ok();
    tick();
    inst_cancel = 1'b1; inst_req = 1'b0;
    tick();
    inst_cancel = 1'b0;
    wait_quiet();

    // cancel while data owns the bus is ignored
    push_data(1'b0, 2'd2, 32'h8000_0040, 32'h0, 4'h0);
    wait_addr_ok();
    tick();
    inst_cancel = 1'b1;
    tick();
    inst_cancel = 1'b0;
    wait_quiet();

    // stores: byte, half, misaligned word, aligned word, size code 3
    mis_base = mis_cnt;
    push_data(1'b1, 2'd0, 32'h8000_0003, 32'h5500_0000, 4'b1000);
    push_data(1'b1, 2'd1, 32'h8000_0002, 32'hBEEF_0000, 4'b1100);
    push_data(1'b1, 2'd2, 32'h8000_0006, 32'h1234_5678, 4'b0000);
    push_data(1'b1, 2'd2, 32'h8000_0008, 32'h8765_4321, 4'b1111);
    push_data(1'b1, 2'd3, 32'h8000_000C, 32'hCAFE_F00D, 4'b1111);
    push_data(1'b1, 2'd0, 32'h8000_0011, 32'h0000_AB00, 4'b0010);
    wait_quiet();
    check_val("misalign_pulses", mis_cnt - mis_base, 1);

    // address phase withheld for 5 cycles
    addr_dly = 5;
    push_data(1'b0, 2'd2, 32'h8000_0050, 32'h0, 4'h0);
    wait_quiet();
    addr_dly = 0;

    // reset asserted in ADDR, stray data_ok afterwards
    bus_en = 1'b0;
    data_addr = 32'h8000_0060; data_wr = 1'b0; data_size = 2'd2; data_req = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check_val("t6_bus_req_addr", bus_req, 1);
    #1;
    rst = 1'b0;
    data_req = 1'b0;
    #1;
    check_val("t6_bus_req_rst", bus_req, 0);
    tick();
    rst = 1'b1;
    tick();
    bus_data_ok = 1'b1;
    bus_rdata = 32'h1111_2222;
    @(negedge clk);
    check_val("t6_late_ok", {inst_data_ok, data_data_ok}, 0);
    check_val("t6_idle_bus_req", bus_req, 0);
    tick();
    bus_en = 1'b1;
    push_inst(32'hBFC0_0300, 1'b0);
    wait_quiet();
    check_val("t6_refetch_latency", last_inst_lat, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
